dmio_gpio: RTL and testbench
============================

Name: dmio_gpio

Overview:
- Parametrised successor to the processor's data-memory/IO block.
- Single memory-mapped slave on the datapath: word-addressed RAM plus a GPIO window.
- GPIO window holds a synchronised switch port, an edge-capture register and a read/write LED register.
- Adds registered reads with a valid flag, an address-error flag, and optional switch debounce.

Parameters:
- ADDR_W, 13, address width in words.
- DATA_W, 64, data word width.
- MEM_DEPTH, 1024, RAM words at addresses 0..MEM_DEPTH-1. Must be ≤ IO_BASE.
- N_SW, 8, switch inputs. Must be ≤ DATA_W.
- N_LED, 8, LED outputs. Must be ≤ DATA_W.
- IO_BASE, 13'h1F00, first GPIO register address.
- DB_CYCLES, 16, debounce stability count. Used only with DMIO_DEBOUNCE_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- direccion  in  ADDR_W  word address.
- dataWrite  in  DATA_W  write data.
- memWr  in  1  write strobe, sampled on rising clk.
- memRd  in  1  read strobe, sampled on rising clk.
- sw  in  N_SW  asynchronous switch inputs.
- lecturaLED  out  N_LED  LED register contents.
- dataRead  out  DATA_W  registered read data.
- rd_valid  out  1  high one cycle after an accepted memRd.
- addr_err  out  1  one-cycle pulse on access to an unmapped address.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - lecturaLED=0, dataRead=0, rd_valid=0, addr_err=0.
  - Switch sync/debounce state=0, edge-capture=0.
  - RAM contents are not reset.
- Address map:
  - [0, MEM_DEPTH-1]: RAM.
  - IO_BASE+0 SW_IN (RO): synchronised or debounced switches, zero-extended.
  - IO_BASE+1 LED (RW): write takes dataWrite[N_LED-1:0]; read returns the register zero-extended.
  - IO_BASE+2 SW_EDGE (RW1C): bit i sets on a rising edge of the filtered sw[i]. Writing 1 clears the bit; writing 0 has no effect.
  - IO_BASE+3 ID (RO): constant {DATA_W-16 zeros, 16'hD10A}.
  - Any other address is unmapped.
- Switch path:
  - Two-flop synchroniser per bit.
  - Edge detect compares the current filtered value with the previous filtered value.
- Writes: memWr=1 at a rising clk commits that edge. Writes to RO or unmapped addresses are ignored.
- Reads:
  - memRd=1 at edge N: dataRead is updated and rd_valid=1 after edge N, so data is visible in cycle N+1.
  - Latency is exactly 1 cycle. Back-to-back reads are allowed, one per cycle.
  - dataRead holds its last value when memRd=0. rd_valid is 0 in any cycle that does not follow a read.
  - Unmapped read returns 0, still with rd_valid=1.
- Simultaneous events:
  - memRd and memWr to the same address at one edge: the read returns the pre-write value and the write commits.
  - SW_EDGE hardware set and W1C clear of the same bit at one edge: the set wins and the bit stays 1.
  - Reading SW_EDGE does not clear it.
- addr_err is a 1-cycle pulse after any edge with (memRd|memWr)=1 and an unmapped direccion.
- Reset asserted mid-access: the access is aborted and outputs go to reset values immediately. A RAM write coinciding with the reset assertion is not guaranteed.
- Widths:
  - Address comparisons use the full ADDR_W.
  - N_SW/N_LED bits map to the LSBs of the register; unused upper bits read 0.

Optional Feature:
- Macro: DMIO_DEBOUNCE_EN.
- Defined:
  - Each synchronised switch bit has a counter.
  - The filtered value changes only after the synchronised input has differed from it for DB_CYCLES consecutive cycles.
  - Any mismatch-free cycle resets the counter.
  - Counter width is clog2(DB_CYCLES+1).
- Undefined: the filtered value equals the synchroniser output, and there are no counters.
- Total sw-to-SW_IN latency: 2 cycles without the macro; 2+DB_CYCLES with it.

Test Plan:
- Reset, then RAM at address 13'h3 → dataRead=0, rd_valid=0, lecturaLED=0 during and after reset.
  - Write 64'hF to address 13'h3.
  - Read 13'h3 → next cycle dataRead=64'hF, rd_valid=1; following idle cycle rd_valid=0.
- LED register:
  - Write 64'hCA to IO_BASE+1 → lecturaLED=8'hCA after the edge.
  - Read IO_BASE+1 → 64'hCA.
  - Assert rst_n=0 mid-cycle → lecturaLED=0 without a clock edge.
- Switches and edges, macro undefined:
  - Set sw=8'h05 → SW_IN reads 64'h05 from the 3rd edge on; SW_EDGE reads 64'h05.
  - Write 64'h01 to SW_EDGE → SW_EDGE reads 64'h04.
  - Hold a switch rising edge on the same edge as a W1C of that bit → the bit stays 1.
- Read-during-write: RAM[13'h10]=64'hA; then memWr=memRd=1 to 13'h10 with dataWrite=64'hB → dataRead=64'hA; a subsequent read returns 64'hB.
- Unmapped address 13'h1AF2:
  - Write then read → dataRead=0, rd_valid=1, addr_err pulses 1 cycle for each access.
  - RAM and LED are unchanged.
  - ID read at IO_BASE+3 → 64'hD10A.
- DMIO_DEBOUNCE_EN defined, DB_CYCLES=16:
  - sw[0] glitch high for 10 cycles → SW_IN[0]=0, no edge captured.
  - Hold high for 20 cycles → SW_IN[0]=1 exactly 18 cycles after the change, and SW_EDGE[0]=1.

Source files
------------

// File: rtl/dmio_gpio.sv
`default_nettype none
// ============================================================================
// Module   : dmio_gpio
// Purpose  : Memory-mapped data-memory/IO slave. It contains a word-addressed
//            RAM and a GPIO window with a switch port, a switch edge-capture
//            register, an LED register and an ID register. Reads are
//            registered and carry a valid flag. Accesses to unmapped
//            addresses raise a one-cycle error pulse.
// Options  : Define DMIO_DEBOUNCE_EN to enable the per-bit switch debounce
//            filter (DB_CYCLES stable cycles).
// Revision : 1.0 - initial release
// ============================================================================
module dmio_gpio #(
  parameter int                ADDR_W    = 13,
  parameter int                DATA_W    = 64,
  parameter int                MEM_DEPTH = 1024,
  parameter int                N_SW      = 8,
  parameter int                N_LED     = 8,
  parameter logic [ADDR_W-1:0] IO_BASE   = 13'h1F00,
  parameter int                DB_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] direccion,
  input  logic [DATA_W-1:0] dataWrite,
  input  logic              memWr,
  input  logic              memRd,
  input  logic [N_SW-1:0]   sw,
  output logic [N_LED-1:0]  lecturaLED,
  output logic [DATA_W-1:0] dataRead,
  output logic              rd_valid,
  output logic              addr_err
);

  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [ADDR_W-1:0] A_SW_IN  = IO_BASE;
  localparam logic [ADDR_W-1:0] A_LED    = IO_BASE + ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_SW_EDG = IO_BASE + ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_ID     = IO_BASE + ADDR_W'(3);
  localparam logic [15:0]       ID_VALUE = 16'hD10A;

  // Storage and state
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [N_SW-1:0]   sync1_q, sync2_q;
  logic [N_SW-1:0]   filt_prev_q;
  logic [N_SW-1:0]   edge_q, edge_d;
  logic [N_LED-1:0]  led_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rd_valid_q;
  logic              addr_err_q;

  // Decode and datapath wires
  logic [N_SW-1:0]   w_filt;
  logic [N_SW-1:0]   w_rise;
  logic [N_SW-1:0]   w_clr;
  logic [MEM_AW-1:0] w_mem_idx;
  logic              w_is_ram, w_is_sw, w_is_led, w_is_edge, w_is_id, w_mapped;
  logic [DATA_W-1:0] w_rd_data;

  assign w_mem_idx = direccion[MEM_AW-1:0];
  assign w_is_ram  = (direccion < ADDR_W'(MEM_DEPTH));
  assign w_is_sw   = (direccion == A_SW_IN);
  assign w_is_led  = (direccion == A_LED);
  assign w_is_edge = (direccion == A_SW_EDG);
  assign w_is_id   = (direccion == A_ID);
  assign w_mapped  = w_is_ram | w_is_sw | w_is_led | w_is_edge | w_is_id;

  // Two-flop synchroniser for the asynchronous switch inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
    end
  end

`ifdef DMIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DB_CYCLES + 1);

  for (genvar i = 0; i < N_SW; i++) begin : g_db
    logic [CNT_W-1:0] cnt_q;
    logic             filt_q;

    // Flip the filtered bit once the input has disagreed for DB_CYCLES cycles
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        filt_q <= 1'b0;
      end else if (sync2_q[i] != filt_q) begin
        if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
          cnt_q  <= '0;
          filt_q <= sync2_q[i];
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end

    assign w_filt[i] = filt_q;
  end
`else
  assign w_filt = sync2_q;
`endif

  // A rising edge is a 0->1 transition of the filtered value.
  // A hardware set takes priority over a same-edge write-1-to-clear.
  assign w_rise = w_filt & ~filt_prev_q;
  assign w_clr  = (memWr && w_is_edge) ? dataWrite[N_SW-1:0] : '0;
  assign edge_d = (edge_q & ~w_clr) | w_rise;

  // Edge history, edge-capture and LED registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_prev_q <= '0;
      edge_q      <= '0;
      led_q       <= '0;
    end else begin
      filt_prev_q <= w_filt;
      edge_q      <= edge_d;
      if (memWr && w_is_led) begin
        led_q <= dataWrite[N_LED-1:0];
      end
    end
  end

  // RAM write port. Its contents survive reset.
  always_ff @(posedge clk) begin
    if (memWr && w_is_ram) begin
      mem_q[w_mem_idx] <= dataWrite;
    end
  end

  // Read mux. Values come from the state before the current edge, so a
  // same-edge write to the same address is not visible in this read.
  always_comb begin
    w_rd_data = '0;
    if (w_is_ram) begin
      w_rd_data = mem_q[w_mem_idx];
    end else if (w_is_sw) begin
      w_rd_data = DATA_W'(w_filt);
    end else if (w_is_led) begin
      w_rd_data = DATA_W'(led_q);
    end else if (w_is_edge) begin
      w_rd_data = DATA_W'(edge_q);
    end else if (w_is_id) begin
      w_rd_data = DATA_W'(ID_VALUE);
    end
  end

  // Registered read data, read-valid and address-error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      rd_valid_q <= memRd;
      addr_err_q <= (memRd | memWr) & ~w_mapped;
      if (memRd) begin
        rdata_q <= w_rd_data;
      end
    end
  end

  assign lecturaLED = led_q;
  assign dataRead   = rdata_q;
  assign rd_valid   = rd_valid_q;
  assign addr_err   = addr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmio_gpio.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmio_gpio
// Purpose  : Scoreboard bench for dmio_gpio. Each driven cycle pushes the
//            expected response, and a monitor compares it after the edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmio_gpio;

  localparam logic [12:0] IO      = 13'h1F00;
  localparam logic [12:0] A_SWIN  = IO;
  localparam logic [12:0] A_LED   = IO + 13'd1;
  localparam logic [12:0] A_EDGE  = IO + 13'd2;
  localparam logic [12:0] A_ID    = IO + 13'd3;
  localparam logic [12:0] A_UNMAP = 13'h1AF2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] direccion = '0;
  logic [63:0] dataWrite = '0;
  logic        memWr = 1'b0;
  logic        memRd = 1'b0;
  logic [7:0]  sw = '0;
  logic [7:0]  lecturaLED;
  logic [63:0] dataRead;
  logic        rd_valid;
  logic        addr_err;

  dmio_gpio dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .direccion  (direccion),
    .dataWrite  (dataWrite),
    .memWr      (memWr),
    .memRd      (memRd),
    .sw         (sw),
    .lecturaLED (lecturaLED),
    .dataRead   (dataRead),
    .rd_valid   (rd_valid),
    .addr_err   (addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    logic [63:0] data;
    bit          err;
    logic [7:0]  led;
  } item_t;

  item_t       sb_q[$];
  item_t       mon_it;
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [7:0]  exp_led = '0;
  logic [7:0]  sw_nx = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Drive one access on the next falling edge and queue its expected result
  task automatic cyc(input bit rd, input bit wr, input logic [12:0] a,
                     input logic [63:0] wd, input logic [63:0] exp_d, input bit err);
    item_t it;
    @(negedge clk);
    sw        = sw_nx;
    memRd     = rd;
    memWr     = wr;
    direccion = a;
    dataWrite = wd;
    if (wr && a == A_LED) exp_led = wd[7:0];
    it.rd   = rd;
    it.data = exp_d;
    it.err  = err;
    it.led  = exp_led;
    sb_q.push_back(it);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 13'h0, 64'h0, 64'h0, 1'b0);
  endtask

  // Monitor: after each edge, compare the DUT outputs with the oldest entry
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_it = sb_q.pop_front();
      chk("rd_valid", {63'h0, rd_valid}, {63'h0, mon_it.rd});
      chk("addr_err", {63'h0, addr_err}, {63'h0, mon_it.err});
      chk("lecturaLED", {56'h0, lecturaLED}, {56'h0, mon_it.led});
      if (mon_it.rd) chk("dataRead", dataRead, mon_it.data);
    end else if (rst_n && rd_valid) begin
      chk("unexpected rd_valid", {63'h0, rd_valid}, 64'h0);
    end
  end

  initial begin
    // Reset state
    #1;
    chk("reset dataRead", dataRead, 64'h0);
    chk("reset rd_valid", {63'h0, rd_valid}, 64'h0);
    chk("reset lecturaLED", {56'h0, lecturaLED}, 64'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // RAM write and read, then an idle cycle
    cyc(1'b0, 1'b1, 13'h3, 64'hF, 64'h0, 1'b0);
    cyc(1'b1, 1'b0, 13'h3, 64'h0, 64'hF, 1'b0);
    idle(1);

    // LED register
    cyc(1'b0, 1'b1, A_LED, 64'hCA, 64'h0, 1'b0);
    cyc(1'b1, 1'b0, A_LED, 64'h0, 64'hCA, 1'b0);
    cyc(1'b1, 1'b0, A_ID, 64'h0, 64'hD10A, 1'b0);

    // Last RAM word and the first address past the RAM
    cyc(1'b0, 1'b1, 13'h3FF, 64'h1234_5678_9ABC_DEF0, 64'h0, 1'b0);
    cyc(1'b1, 1'b0, 13'h3FF, 64'h0, 64'h1234_5678_9ABC_DEF0, 1'b0);
    cyc(1'b1, 1'b0, 13'h400, 64'h0, 64'h0, 1'b1);
    cyc(1'b1, 1'b0, IO + 13'd4, 64'h0, 64'h0, 1'b1);

`ifndef DMIO_DEBOUNCE_EN
    // Switches: the change reaches SW_IN after two edges and SW_EDGE after three
    sw_nx = 8'h05;
    idle(1);
    cyc(1'b1, 1'b0, A_SWIN, 64'h0, 64'h0, 1'b0);
    cyc(1'b1, 1'b0, A_SWIN, 64'h0, 64'h05, 1'b0);
    cyc(1'b1, 1'b0, A_EDGE, 64'h0, 64'h05, 1'b0);
    cyc(1'b1, 1'b0, A_EDGE, 64'h0, 64'h05, 1'b0);
    // W1C of bit 0
    cyc(1'b0, 1'b1, A_EDGE, 64'h01, 64'h0, 1'b0);
    cyc(1'b1, 1'b0, A_EDGE, 64'h0, 64'h04, 1'b0);
    // sw[1] rises; its capture coincides with a W1C of bit 1, and the set wins
    sw_nx = 8'h07;
    idle(2);
    cyc(1'b0, 1'b1, A_EDGE, 64'h02, 64'h0, 1'b0);
    cyc(1'b1, 1'b0, A_EDGE, 64'h0, 64'h06, 1'b0);
    cyc(1'b1, 1'b0, A_SWIN, 64'h0, 64'h07, 1'b0);
`else
    // Debounce: a 10-cycle glitch is rejected
    sw_nx = 8'h01;
    idle(10);
    sw_nx = 8'h00;
    idle(20);
    cyc(1'b1, 1'b0, A_SWIN, 64'h0, 64'h0, 1'b0);
    cyc(1'b1, 1'b0, A_EDGE, 64'h0, 64'h0, 1'b0);
    // A stable level passes after exactly 18 edges
    sw_nx = 8'h01;
    idle(17);
    cyc(1'b1, 1'b0, A_SWIN, 64'h0, 64'h0, 1'b0);
    cyc(1'b1, 1'b0, A_SWIN, 64'h0, 64'h1, 1'b0);
    cyc(1'b1, 1'b0, A_EDGE, 64'h0, 64'h1, 1'b0);
`endif

    // Read-during-write returns the old value
    cyc(1'b0, 1'b1, 13'h10, 64'hA, 64'h0, 1'b0);
    cyc(1'b1, 1'b1, 13'h10, 64'hB, 64'hA, 1'b0);
    cyc(1'b1, 1'b0, 13'h10, 64'h0, 64'hB, 1'b0);

    // Unmapped address: write and read both flag an error; nothing changes
    cyc(1'b0, 1'b1, A_UNMAP, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    cyc(1'b1, 1'b0, A_UNMAP, 64'h0, 64'h0, 1'b1);
    idle(1);
    cyc(1'b1, 1'b0, 13'h3, 64'h0, 64'hF, 1'b0);
    cyc(1'b1, 1'b0, A_LED, 64'h0, 64'hCA, 1'b0);
    cyc(1'b1, 1'b0, A_ID, 64'h0, 64'hD10A, 1'b0);

    // Asynchronous reset between edges, right after a read completes
    cyc(1'b1, 1'b0, 13'h3, 64'h0, 64'hF, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    memRd = 1'b0;
    memWr = 1'b0;
    sw_nx = 8'h00;
    sw    = 8'h00;
    exp_led = 8'h00;
    #1;
    chk("async reset lecturaLED", {56'h0, lecturaLED}, 64'h0);
    chk("async reset dataRead", dataRead, 64'h0);
    chk("async reset rd_valid", {63'h0, rd_valid}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // RAM keeps its contents across reset; the LED register does not
    cyc(1'b1, 1'b0, 13'h3, 64'h0, 64'hF, 1'b0);
    cyc(1'b1, 1'b0, A_LED, 64'h0, 64'h0, 1'b0);
    idle(1);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 100 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    chk("scoreboard drained", 64'(sb_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
